// File: rtl/seg_scan_display.sv
// Time-multiplexed hex seven-segment driver: scans NUM_DIGITS digits with
// blanking, leading-zero suppression, PWM brightness and a frame strobe.
module seg_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 22,
  parameter int BRIGHT_W   = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dots,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int   CW  = $clog2(TICK_DIV);
  localparam int   IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Wide enough for (2**BRIGHT_W)*TICK_DIV so the PWM compare never truncates.
  localparam int   PW  = CW + BRIGHT_W + 1;
  localparam logic OFF = (ACTIVE_LOW != 0);

  logic [CW-1:0] div_cnt;
  logic [IW-1:0] idx;
  logic          primed;

  logic                    slot_wrap;
  logic [3:0]              digit_val;
  logic [4*NUM_DIGITS-1:0] upper;
  logic                    suppressed;
  logic [PW-1:0]           pwm_lhs, pwm_rhs;
  logic                    pwm_on;
  logic [6:0]              seg_on;
  logic                    dp_on;
  logic                    an_on;
  logic [NUM_DIGITS-1:0]   an_hot;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic                    fs_n;

  // Active-high abcdefg, seg[6] = a.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'b1111110;
      4'h1: decode = 7'b0110000;
      4'h2: decode = 7'b1101101;
      4'h3: decode = 7'b1111001;
      4'h4: decode = 7'b0110011;
      4'h5: decode = 7'b1011011;
      4'h6: decode = 7'b1011111;
      4'h7: decode = 7'b1110000;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1111011;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b0011111;
      4'hC: decode = 7'b1001110;
      4'hD: decode = 7'b0111101;
      4'hE: decode = 7'b1001111;
      default: decode = 7'b1000111;
    endcase
  endfunction

  assign slot_wrap = (div_cnt == CW'(TICK_DIV - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    an_hot     = '0;
    seg_on     = 7'b0;
    dp_on      = 1'b0;
    an_on      = 1'b0;
    digit_val  = digits[4*int'(idx) +: 4];
    upper      = digits >> (4 * int'(idx));
    suppressed = lz_suppress && (idx != '0) && (upper == '0);
    pwm_lhs    = PW'(div_cnt) << BRIGHT_W;
    pwm_rhs    = (PW'(brightness) + PW'(1)) * PW'(TICK_DIV);
    pwm_on     = (pwm_lhs < pwm_rhs);

    if (blank[idx]) begin
      an_on = 1'b0;
    end else if (suppressed) begin
      dp_on = dots[idx];
      an_on = dots[idx] && pwm_on;
    end else begin
      seg_on = decode(digit_val);
      dp_on  = dots[idx];
      an_on  = pwm_on;
    end

    an_hot[idx] = an_on;
    an_n  = OFF ? ~an_hot : an_hot;
    seg_n = OFF ? ~seg_on : seg_on;
    dp_n  = OFF ? ~dp_on  : dp_on;
    // primed keeps the very first slot-0 after reset from strobing.
    fs_n  = primed && (div_cnt == '0) && (idx == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= '0;
      primed      <= 1'b0;
      an          <= {NUM_DIGITS{OFF}};
      seg         <= {7{OFF}};
      dp          <= OFF;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      div_cnt     <= slot_wrap ? '0 : div_cnt + CW'(1);
      if (slot_wrap)
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
      primed      <= 1'b1;
      an          <= an_n;
      seg         <= seg_n;
      dp          <= dp_n;
      frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: cycle-count reference model
// compared every cycle, plus directed literal checks and random stimulus.
module tb_seg_scan_display;

  localparam int N  = 4;
  localparam int TD = 22;
  localparam int B  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [4*N-1:0] digits;
  logic [N-1:0] dots, blank;
  logic         lz_suppress;
  logic [B-1:0] brightness;
  logic [N-1:0] an;
  logic [6:0]   seg;
  logic         dp;
  logic         frame_start;

  int vectors    = 0;
  int miscompares = 0;
  int edge_n     = 0;
  bit check_en   = 1'b0;

  seg_scan_display #(.NUM_DIGITS(N), .TICK_DIV(TD), .BRIGHT_W(B), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .digits(digits), .dots(dots), .blank(blank),
    .lz_suppress(lz_suppress), .brightness(brightness),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Active-high abcdefg glyphs, indexed by hex value.
  logic [6:0] glyph [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Reference model: outputs are a function of cycles since reset and the inputs.
  int         m_c = 0;
  logic [N-1:0] e_an;
  logic [6:0]   e_seg;
  logic         e_dp, e_fs;

  always @(posedge clk) begin
    int div, slot;
    bit sup, lit, on;
    if (rst) begin
      m_c = 0;
      e_an = '1; e_seg = '1; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      div  = m_c % TD;
      slot = (m_c / TD) % N;
      on   = (div * (1 << B)) < ((int'(brightness) + 1) * TD);
      sup  = lz_suppress && slot > 0 && ((digits >> (4 * slot)) == 0);
      e_an = '1; e_seg = '1; e_dp = 1'b1;
      if (!blank[slot]) begin
        e_dp = !dots[slot];
        if (sup) lit = dots[slot] && on;
        else begin
          lit   = on;
          e_seg = ~glyph[(digits >> (4 * slot)) & 16'hF];
        end
        if (lit) e_an[slot] = 1'b0;
      end
      e_fs = (m_c > 0) && (m_c % (N * TD) == 0);
      m_c++;
    end
    #1;
    if (check_en) begin
      check("model_an",  32'(an),          32'(e_an));
      check("model_seg", 32'(seg),         32'(e_seg));
      check("model_dp",  32'(dp),          32'(e_dp));
      check("model_fs",  32'(frame_start), 32'(e_fs));
    end
  end

  // Asynchronous reset mid-slot, then release so the next edge is slot 0.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_an",  32'(an),          32'hF);
    check("rst_seg", 32'(seg),         32'h7F);
    check("rst_dp",  32'(dp),          32'h1);
    check("rst_fs",  32'(frame_start), 32'h0);
    step();
    rst = 1'b0;
    edge_n = 0;
  endtask

  int cnt, first_fs, second_fs;

  initial begin
    rst = 1'b1; digits = '0; dots = '0; blank = '0;
    lz_suppress = 1'b0; brightness = 3'd7;
    repeat (3) step();
    check("reset_an", 32'(an), 32'hF);
    check_en = 1'b1;

    // Scan of 1234
    digits = 16'h1234;
    rst = 1'b0; edge_n = 0;
    step();
    check("scan_s0_an",  32'(an),  32'hE);
    check("scan_s0_seg", 32'(seg), 32'b1001100);
    repeat (22) step();
    check("scan_s1_an",  32'(an),  32'hD);
    check("scan_s1_seg", 32'(seg), 32'b0000110);
    repeat (5) step();
    do_reset();
    first_fs = 0; second_fs = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (frame_start) begin
        if (first_fs == 0) first_fs = edge_n;
        else if (second_fs == 0) second_fs = edge_n;
      end
    end
    check("fs_first",  32'(first_fs),             32'd89);
    check("fs_period", 32'(second_fs - first_fs), 32'd88);

    // Hex glyphs b and d
    digits = 16'h00BD;
    do_reset();
    step();
    check("hex_d", 32'(seg), 32'b1000010);
    repeat (22) step();
    check("hex_b", 32'(seg), 32'b1100000);
    repeat (22) step();
    check("hex_0", 32'(seg), 32'b0000001);

    // Leading-zero suppression
    digits = 16'h0040; lz_suppress = 1'b1;
    do_reset();
    cnt = 0;
    for (int k = 1; k <= 88; k++) begin
      step();
      if (!an[3] || !an[2]) cnt++;
      if (k == 1)  check("lz_s0_seg", 32'(seg), 32'b0000001);
      if (k == 23) check("lz_s1_seg", 32'(seg), 32'b1001100);
    end
    check("lz_upper_dark", 32'(cnt), 32'd0);
    digits = 16'h0000; dots = 4'b1000;
    do_reset();
    repeat (67) step();
    check("lz_dot_an",  32'(an),  32'b0111);
    check("lz_dot_seg", 32'(seg), 32'h7F);
    check("lz_dot_dp",  32'(dp),  32'h0);
    lz_suppress = 1'b0; dots = '0; digits = 16'h1234;

    // Brightness duty per slot
    brightness = 3'd0;
    do_reset();
    cnt = 0;
    for (int k = 0; k < 22; k++) begin step(); if (an != 4'hF) cnt++; end
    check("bright0_on", 32'(cnt), 32'd3);
    brightness = 3'd3;
    do_reset();
    cnt = 0;
    for (int k = 0; k < 22; k++) begin step(); if (an != 4'hF) cnt++; end
    check("bright3_on", 32'(cnt), 32'd11);
    brightness = 3'd7;
    do_reset();
    repeat (10) step();
    check("bright_pre_an", 32'(an), 32'hE);
    brightness = 3'd0;
    step();
    check("bright_post_an", 32'(an), 32'hF);
    brightness = 3'd7;

    // Blank and dots
    blank = 4'b0100; dots = 4'b0110;
    do_reset();
    step();
    check("bd_s0_dp", 32'(dp), 32'h1);
    repeat (22) step();
    check("bd_s1_dp", 32'(dp), 32'h0);
    repeat (22) step();
    check("bd_s2_an", 32'(an), 32'hF);
    check("bd_s2_dp", 32'(dp), 32'h1);
    repeat (22) step();
    check("bd_s3_dp", 32'(dp), 32'h1);

    // Random stimulus against the model
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int d = 0; d < N; d++)
          digits[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        dots        = N'($urandom);
        blank       = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
        lz_suppress = 1'($urandom);
        brightness  = B'($urandom);
      end
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised, time-multiplexed seven-segment display driver for common-anode displays. It scans NUM_DIGITS hex digits at a programmable refresh rate, and adds per-digit blanking, leading-zero suppression, PWM brightness control and a frame-start strobe. It sits between the application's value registers and the board's anode and cathode pins. Correct hex glyphs (including b and d) are decoded for all 16 values.

## Interface
Parameters:
- NUM_DIGITS, 4: digits scanned, legal range 1..8.
- TICK_DIV, 22: clk cycles per digit slot, minimum 2.
- BRIGHT_W, 3: brightness field width.
- ACTIVE_LOW, 1: 1 means an, seg and dp are active-low; 0 means active-high.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- digits  in  4*NUM_DIGITS  digit i is digits[4i+3:4i]; digit 0 is rightmost.
- dots  in  NUM_DIGITS  decimal point request per digit.
- blank  in  NUM_DIGITS  forces a digit fully dark (anode, segments and dp).
- lz_suppress  in  1  enables leading-zero suppression.
- brightness  in  BRIGHT_W  duty level; 0 is dimmest, all-ones is full on.
- an  out  NUM_DIGITS  anode enables; an[i] drives digit i.
- seg  out  7  segments {a,b,c,d,e,f,g}, with seg[6]=a.
- dp  out  1  decimal point.
- frame_start  out  1  one-cycle pulse at the start of each scan frame.

## Operation
- div_cnt counts 0..TICK_DIV-1 and wraps.
  - On wrap, idx advances 0,1,..,NUM_DIGITS-1 and then back to 0.
  - With NUM_DIGITS=1, idx stays at 0.
- Glyph decode, active-high pattern abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Leading-zero suppression applies when lz_suppress=1.
  - Digit i (i>0) is suppressed if digits i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - A suppressed digit shows no segments. Its anode is on only if dots[i]=1, and then only dp is lit.
- Blanking has priority over everything else: blank[idx]=1 turns the anode, segments and dp off.
- PWM gate: on = (div_cnt << BRIGHT_W) < (brightness+1)*TICK_DIV.
  - Evaluate at full width; no truncation is allowed.
  - When on=0, the anode is inactive. Segments and dp still hold the current glyph.
- Drive levels:
  - At most one anode is active at any time.
  - Inactive level is 1 when ACTIVE_LOW=1 and 0 otherwise.
  - Every active output is the inversion of its inactive level.
- Inputs are not snapshotted. digits, dots, blank, lz_suppress and brightness are sampled every cycle.

## Timing
- All outputs are registered. Each output reflects div_cnt, idx and the inputs from the previous cycle, so latency is 1 clk.
- Reset values take effect immediately, asynchronously:
  - div_cnt=0, idx=0, frame_start=0.
  - an, seg and dp are at their inactive level.
- On the first edge after rst deasserts, outputs show slot 0 with div_cnt=0.
- frame_start goes high for exactly one cycle, coincident with the first output cycle of slot 0 following the idx wrap NUM_DIGITS-1→0.
  - It does not pulse after reset.
  - The period is NUM_DIGITS*TICK_DIV cycles.
- Brightness is applied within a slot. For TICK_DIV=22 and BRIGHT_W=3:
  - Level 0 gives 3 on-cycles.
  - Level 3 gives 11 on-cycles.
  - Level 7 gives 22 on-cycles.
- Input changes mid-slot are visible on the next cycle. There is no glitch hold.
- If rst is asserted mid-slot, outputs go inactive in the same cycle. The scan restarts at slot 0.
- Digit transitions:
  - An anode switching from digit i to digit i+1 happens in one registered update, with no overlap cycle.
  - Segments change on that same edge.

## Test plan
Unless stated otherwise, defaults apply: NUM_DIGITS=4, TICK_DIV=22, BRIGHT_W=3, ACTIVE_LOW=1, brightness=7, lz_suppress=0, blank=0, dots=0.
- Reset mid-slot:
  - Assert rst asynchronously → an=1111, seg=1111111, dp=1, frame_start=0 before the next edge.
  - Release rst → one edge later an=1110.
- Scan of digits=16'h1234:
  - Slot 0 shows seg=1001100 ("4") with an=1110 for 22 cycles.
  - Then an=1101 with seg=0000110 ("3"), and so on.
  - frame_start pulses every 88 cycles.
- Hex glyphs with digits=16'h00BD:
  - Slot 0: seg=1000010 (d).
  - Slot 1: seg=1100000 (b).
  - Slots 2 and 3: seg=0000001 (0).
- Leading-zero suppression with lz_suppress=1:
  - digits=16'h0040 → an[3] and an[2] never go low; slot 1 shows "4"; slot 0 shows "0".
  - digits=16'h0000 with dots=4'b1000 → slot 3 has an[3]=0, seg=1111111, dp=0.
- Brightness:
  - brightness=0 → an low for 3 of 22 cycles per slot.
  - brightness=3 → 11 of 22.
  - Changing brightness 7→0 at div_cnt=10 → anode inactive from the next cycle.
- Blank and dots:
  - blank=4'b0100, dots=4'b0110 → slot 2 has an=1111 and dp=1.
  - Slot 1 has dp=0.
  - Slots 0 and 3 have dp=1.
